// File: rtl/noc_link_pipe_mon.sv
// Router-to-router link stage: retimes flits and credits, and monitors each link's
// credit flow, packet framing and traffic statistics.
module noc_link_pipe_mon #(
  parameter int NUM_LINKS         = 4,
  parameter int FLIT_WIDTH        = 128,
  parameter int DEST_WIDTH        = 6,
  parameter int NUM_PIPELINE      = 2,
  parameter int FLIT_BUFFER_DEPTH = 4,
  parameter int STAT_WIDTH        = 16,
  localparam int CREDIT_WIDTH     = $clog2(FLIT_BUFFER_DEPTH + 1)
) (
  input  logic                                    clk_noc,
  input  logic                                    rst_n,
  input  logic [NUM_LINKS-1:0][FLIT_WIDTH-1:0]    data_in,
  input  logic [NUM_LINKS-1:0][DEST_WIDTH-1:0]    dest_in,
  input  logic [NUM_LINKS-1:0]                    is_tail_in,
  input  logic [NUM_LINKS-1:0]                    send_in,
  output logic [NUM_LINKS-1:0]                    credit_out,
  output logic [NUM_LINKS-1:0][FLIT_WIDTH-1:0]    data_out,
  output logic [NUM_LINKS-1:0][DEST_WIDTH-1:0]    dest_out,
  output logic [NUM_LINKS-1:0]                    is_tail_out,
  output logic [NUM_LINKS-1:0]                    send_out,
  input  logic [NUM_LINKS-1:0]                    credit_in,
  input  logic                                    clear_stats,
  output logic [NUM_LINKS-1:0][CREDIT_WIDTH-1:0]  credits_avail,
  output logic [NUM_LINKS-1:0]                    pkt_active,
  output logic [NUM_LINKS-1:0][STAT_WIDTH-1:0]    flit_count,
  output logic [NUM_LINKS-1:0][STAT_WIDTH-1:0]    pkt_count,
  output logic [NUM_LINKS-1:0]                    err_underflow,
  output logic [NUM_LINKS-1:0]                    err_overflow,
  output logic [NUM_LINKS-1:0]                    err_framing
);

  localparam logic [CREDIT_WIDTH-1:0] CREDIT_MAX = CREDIT_WIDTH'(FLIT_BUFFER_DEPTH);
  localparam logic [STAT_WIDTH-1:0]   STAT_MAX   = '1;

  typedef enum logic {
    IDLE   = 1'b0,
    IN_PKT = 1'b1
  } frame_state_t;

  // ---------------------------------------------------------------------------
  // Forward and credit retiming
  // ---------------------------------------------------------------------------
  generate
    if (NUM_PIPELINE == 0) begin : g_wire
      assign data_out    = data_in;
      assign dest_out    = dest_in;
      assign is_tail_out = is_tail_in;
      assign send_out    = send_in;
      assign credit_out  = credit_in;
    end else begin : g_pipe
      logic [NUM_PIPELINE-1:0][NUM_LINKS-1:0][FLIT_WIDTH-1:0] data_q, data_src;
      logic [NUM_PIPELINE-1:0][NUM_LINKS-1:0][DEST_WIDTH-1:0] dest_q, dest_src;
      logic [NUM_PIPELINE-1:0][NUM_LINKS-1:0]                 tail_q, tail_src;
      logic [NUM_PIPELINE-1:0][NUM_LINKS-1:0]                 send_q, send_src;
      logic [NUM_PIPELINE-1:0][NUM_LINKS-1:0]                 credit_q, credit_src;

      always_comb begin
        data_src[0]   = data_in;
        dest_src[0]   = dest_in;
        tail_src[0]   = is_tail_in;
        send_src[0]   = send_in;
        credit_src[0] = credit_in;
        for (int s = 1; s < NUM_PIPELINE; s++) begin
          data_src[s]   = data_q[s-1];
          dest_src[s]   = dest_q[s-1];
          tail_src[s]   = tail_q[s-1];
          send_src[s]   = send_q[s-1];
          credit_src[s] = credit_q[s-1];
        end
      end

      // Wide payload registers only toggle when a valid flit passes through
      always_ff @(posedge clk_noc or negedge rst_n) begin
        if (!rst_n) begin
          data_q   <= '0;
          dest_q   <= '0;
          tail_q   <= '0;
          send_q   <= '0;
          credit_q <= '0;
        end else begin
          for (int s = 0; s < NUM_PIPELINE; s++) begin
            tail_q[s]   <= tail_src[s];
            send_q[s]   <= send_src[s];
            credit_q[s] <= credit_src[s];
            for (int l = 0; l < NUM_LINKS; l++) begin
              if (send_src[s][l]) begin
                data_q[s][l] <= data_src[s][l];
                dest_q[s][l] <= dest_src[s][l];
              end
            end
          end
        end
      end

      assign data_out    = data_q[NUM_PIPELINE-1];
      assign dest_out    = dest_q[NUM_PIPELINE-1];
      assign is_tail_out = tail_q[NUM_PIPELINE-1];
      assign send_out    = send_q[NUM_PIPELINE-1];
      assign credit_out  = credit_q[NUM_PIPELINE-1];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Per-link monitor
  // ---------------------------------------------------------------------------
  generate
    for (genvar l = 0; l < NUM_LINKS; l++) begin : g_mon
      frame_state_t              state_q, state_d;
      logic [DEST_WIDTH-1:0]     dest_q;
      logic [CREDIT_WIDTH-1:0]   credit_q;
      logic [STAT_WIDTH-1:0]     flit_q, pkt_q;
      logic                      under_q, over_q, frame_q;
      logic                      under_set, over_set, frame_set;
      logic                      send_only, credit_only;

      assign send_only   = send_in[l] & ~credit_out[l];
      assign credit_only = credit_out[l] & ~send_in[l];
      assign under_set   = send_only & (credit_q == '0);
      assign over_set    = credit_only & (credit_q == CREDIT_MAX);
      assign frame_set   = (state_q == IN_PKT) & send_in[l] & (dest_in[l] != dest_q);

      always_comb begin
        state_d = state_q;
        case (state_q)
          IDLE:    if (send_in[l] & ~is_tail_in[l]) state_d = IN_PKT;
          IN_PKT:  if (send_in[l] & is_tail_in[l])  state_d = IDLE;
          default: state_d = IDLE;
        endcase
      end

      always_ff @(posedge clk_noc or negedge rst_n) begin
        if (!rst_n) begin
          state_q <= IDLE;
          dest_q  <= '0;
        end else begin
          state_q <= state_d;
          if (state_q == IDLE && send_in[l] && !is_tail_in[l]) dest_q <= dest_in[l];
        end
      end

      // Counter saturates at both ends; the out-of-range event is flagged instead
      always_ff @(posedge clk_noc or negedge rst_n) begin
        if (!rst_n) begin
          credit_q <= CREDIT_MAX;
        end else if (send_only && !under_set) begin
          credit_q <= credit_q - 1'b1;
        end else if (credit_only && !over_set) begin
          credit_q <= credit_q + 1'b1;
        end
      end

      always_ff @(posedge clk_noc or negedge rst_n) begin
        if (!rst_n) begin
          flit_q  <= '0;
          pkt_q   <= '0;
          under_q <= 1'b0;
          over_q  <= 1'b0;
          frame_q <= 1'b0;
        end else if (clear_stats) begin
          flit_q  <= '0;
          pkt_q   <= '0;
          under_q <= 1'b0;
          over_q  <= 1'b0;
          frame_q <= 1'b0;
        end else begin
          if (send_in[l] && flit_q != STAT_MAX) flit_q <= flit_q + 1'b1;
          if (send_in[l] && is_tail_in[l] && pkt_q != STAT_MAX) pkt_q <= pkt_q + 1'b1;
          under_q <= under_q | under_set;
          over_q  <= over_q | over_set;
          frame_q <= frame_q | frame_set;
        end
      end

      assign credits_avail[l] = credit_q;
      assign pkt_active[l]    = (state_q == IN_PKT);
      assign flit_count[l]    = flit_q;
      assign pkt_count[l]     = pkt_q;
      assign err_underflow[l] = under_q;
      assign err_overflow[l]  = over_q;
      assign err_framing[l]   = frame_q;
    end
  endgenerate

endmodule

// File: tb/tb_noc_link_pipe_mon.sv
// Directed bench: a 2-stage instance with 16-bit stats and a wire-through instance
// with 4-bit stats share all stimulus.
module tb_noc_link_pipe_mon;
  localparam int NL = 4;
  localparam int FW = 128;
  localparam int DW = 6;
  localparam int CW = 3;

  logic                    clk_noc = 1'b0;
  logic                    rst_n;
  logic [NL-1:0][FW-1:0]   data_in;
  logic [NL-1:0][DW-1:0]   dest_in;
  logic [NL-1:0]           is_tail_in, send_in, credit_in;
  logic                    clear_stats;

  logic [NL-1:0]           credit_out, is_tail_out, send_out, pkt_active;
  logic [NL-1:0]           err_underflow, err_overflow, err_framing;
  logic [NL-1:0][FW-1:0]   data_out;
  logic [NL-1:0][DW-1:0]   dest_out;
  logic [NL-1:0][CW-1:0]   credits_avail;
  logic [NL-1:0][15:0]     flit_count, pkt_count;

  logic [NL-1:0]           credit_out0, is_tail_out0, send_out0, pkt_active0;
  logic [NL-1:0]           err_underflow0, err_overflow0, err_framing0;
  logic [NL-1:0][FW-1:0]   data_out0;
  logic [NL-1:0][DW-1:0]   dest_out0;
  logic [NL-1:0][CW-1:0]   credits_avail0;
  logic [NL-1:0][3:0]      flit_count0, pkt_count0;

  int errors = 0;
  int checks = 0;

  logic [FW-1:0] pat_a, pat_b;

  always #5 clk_noc = ~clk_noc;

  noc_link_pipe_mon #(.NUM_LINKS(NL), .FLIT_WIDTH(FW), .DEST_WIDTH(DW), .NUM_PIPELINE(2),
                      .FLIT_BUFFER_DEPTH(4), .STAT_WIDTH(16)) u_dut (
    .clk_noc(clk_noc), .rst_n(rst_n), .data_in(data_in), .dest_in(dest_in),
    .is_tail_in(is_tail_in), .send_in(send_in), .credit_out(credit_out),
    .data_out(data_out), .dest_out(dest_out), .is_tail_out(is_tail_out),
    .send_out(send_out), .credit_in(credit_in), .clear_stats(clear_stats),
    .credits_avail(credits_avail), .pkt_active(pkt_active), .flit_count(flit_count),
    .pkt_count(pkt_count), .err_underflow(err_underflow), .err_overflow(err_overflow),
    .err_framing(err_framing)
  );

  noc_link_pipe_mon #(.NUM_LINKS(NL), .FLIT_WIDTH(FW), .DEST_WIDTH(DW), .NUM_PIPELINE(0),
                      .FLIT_BUFFER_DEPTH(4), .STAT_WIDTH(4)) u_dut0 (
    .clk_noc(clk_noc), .rst_n(rst_n), .data_in(data_in), .dest_in(dest_in),
    .is_tail_in(is_tail_in), .send_in(send_in), .credit_out(credit_out0),
    .data_out(data_out0), .dest_out(dest_out0), .is_tail_out(is_tail_out0),
    .send_out(send_out0), .credit_in(credit_in), .clear_stats(clear_stats),
    .credits_avail(credits_avail0), .pkt_active(pkt_active0), .flit_count(flit_count0),
    .pkt_count(pkt_count0), .err_underflow(err_underflow0), .err_overflow(err_overflow0),
    .err_framing(err_framing0)
  );

  task automatic tick();
    @(posedge clk_noc);
    #1;
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    data_in     = '0;
    dest_in     = '0;
    is_tail_in  = '0;
    send_in     = '0;
    credit_in   = '0;
    clear_stats = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (send_out !== 4'b0 || credit_out !== 4'b0) begin
      errors++;
      $display("FAIL reset_pipe: send_out=%b credit_out=%b want 0", send_out, credit_out);
    end
    checks++;
    if (credits_avail !== {4{3'd4}}) begin
      errors++;
      $display("FAIL reset_credits: got %h want %h", credits_avail, {4{3'd4}});
    end
    checks++;
    if (pkt_active !== 4'b0 || flit_count !== '0 || pkt_count !== '0 ||
        err_underflow !== 4'b0 || err_overflow !== 4'b0 || err_framing !== 4'b0) begin
      errors++;
      $display("FAIL reset_monitor: pkt_active=%b errs=%b%b%b want all 0",
               pkt_active, err_underflow, err_overflow, err_framing);
    end
  endtask

  task automatic test_pipeline();
    do_reset();
    data_in[1]    = pat_a;
    dest_in[1]    = 6'h2A;
    is_tail_in[1] = 1'b1;
    send_in[1]    = 1'b1;
    #1;
    checks++;
    if (send_out0[1] !== 1'b1 || data_out0[1] !== pat_a) begin
      errors++;
      $display("FAIL wire_fwd: send=%b data=%h want 1 %h", send_out0[1], data_out0[1], pat_a);
    end
    tick();
    send_in[1]    = 1'b0;
    is_tail_in[1] = 1'b0;
    data_in[1]    = pat_b;
    checks++;
    if (send_out[1] !== 1'b0) begin
      errors++;
      $display("FAIL fwd_early: send_out=%b want 0 after 1 cycle", send_out[1]);
    end
    tick();
    checks++;
    if (send_out[1] !== 1'b1 || data_out[1] !== pat_a || dest_out[1] !== 6'h2A ||
        is_tail_out[1] !== 1'b1) begin
      errors++;
      $display("FAIL fwd_delay: send=%b data=%h dest=%h tail=%b want 1 %h 2a 1",
               send_out[1], data_out[1], dest_out[1], is_tail_out[1], pat_a);
    end
    tick();
    tick();
    checks++;
    if (send_out[1] !== 1'b0 || data_out[1] !== pat_a) begin
      errors++;
      $display("FAIL fwd_hold: send=%b data=%h want 0 %h", send_out[1], data_out[1], pat_a);
    end
    // Credit return: cancels the flit above, then a second one overflows
    credit_in[1] = 1'b1;
    #1;
    checks++;
    if (credit_out0[1] !== 1'b1) begin
      errors++;
      $display("FAIL wire_credit: got %b want 1", credit_out0[1]);
    end
    tick();
    credit_in[1] = 1'b0;
    checks++;
    if (credit_out[1] !== 1'b0) begin
      errors++;
      $display("FAIL credit_early: got %b want 0", credit_out[1]);
    end
    tick();
    checks++;
    if (credit_out[1] !== 1'b1) begin
      errors++;
      $display("FAIL credit_delay: got %b want 1", credit_out[1]);
    end
    tick();
    checks++;
    if (credits_avail[1] !== 3'd4 || err_overflow[1] !== 1'b0) begin
      errors++;
      $display("FAIL credit_return: credits=%0d ovf=%b want 4 0", credits_avail[1], err_overflow[1]);
    end
    credit_in[1] = 1'b1;
    tick();
    credit_in[1] = 1'b0;
    tick();
    tick();
    checks++;
    if (credits_avail[1] !== 3'd4 || err_overflow[1] !== 1'b1 || err_overflow0[1] !== 1'b1) begin
      errors++;
      $display("FAIL overflow: credits=%0d ovf=%b ovf0=%b want 4 1 1",
               credits_avail[1], err_overflow[1], err_overflow0[1]);
    end
  endtask

  task automatic test_underflow();
    do_reset();
    dest_in[0]    = 6'h01;
    is_tail_in[0] = 1'b1;
    send_in[0]    = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (credits_avail[0] !== 3'(3 - i) || err_underflow[0] !== 1'b0) begin
        errors++;
        $display("FAIL credit_dec%0d: credits=%0d unf=%b want %0d 0",
                 i, credits_avail[0], err_underflow[0], 3 - i);
      end
    end
    tick();
    send_in[0] = 1'b0;
    checks++;
    if (credits_avail[0] !== 3'd0 || err_underflow[0] !== 1'b1) begin
      errors++;
      $display("FAIL underflow: credits=%0d unf=%b want 0 1", credits_avail[0], err_underflow[0]);
    end
  endtask

  task automatic test_same_cycle();
    do_reset();
    dest_in[0]    = 6'h01;
    is_tail_in[0] = 1'b1;
    send_in[0]    = 1'b1;
    tick();
    tick();
    send_in[0]   = 1'b0;
    credit_in[0] = 1'b1;
    tick();
    credit_in[0] = 1'b0;
    tick();
    send_in[0] = 1'b1;
    tick();
    send_in[0] = 1'b0;
    tick();
    checks++;
    if (credits_avail[0] !== 3'd2 || err_underflow[0] !== 1'b0 || err_overflow[0] !== 1'b0) begin
      errors++;
      $display("FAIL same_cycle: credits=%0d unf=%b ovf=%b want 2 0 0",
               credits_avail[0], err_underflow[0], err_overflow[0]);
    end
  endtask

  task automatic test_framing();
    do_reset();
    send_in[2]    = 1'b1;
    is_tail_in[2] = 1'b0;
    dest_in[2]    = 6'h05;
    tick();
    checks++;
    if (pkt_active[2] !== 1'b1 || err_framing[2] !== 1'b0) begin
      errors++;
      $display("FAIL frame_head: active=%b err=%b want 1 0", pkt_active[2], err_framing[2]);
    end
    dest_in[2] = 6'h06;
    tick();
    checks++;
    if (pkt_active[2] !== 1'b1 || err_framing[2] !== 1'b1) begin
      errors++;
      $display("FAIL frame_body: active=%b err=%b want 1 1", pkt_active[2], err_framing[2]);
    end
    dest_in[2]    = 6'h05;
    is_tail_in[2] = 1'b1;
    tick();
    send_in[2]    = 1'b0;
    is_tail_in[2] = 1'b0;
    checks++;
    if (pkt_active[2] !== 1'b0 || pkt_count[2] !== 16'd1 || flit_count[2] !== 16'd3 ||
        credits_avail[2] !== 3'd1 || err_framing[2] !== 1'b1) begin
      errors++;
      $display("FAIL frame_tail: active=%b pkts=%0d flits=%0d credits=%0d err=%b want 0 1 3 1 1",
               pkt_active[2], pkt_count[2], flit_count[2], credits_avail[2], err_framing[2]);
    end
  endtask

  task automatic test_saturate_clear();
    do_reset();
    send_in[3]    = 1'b1;
    is_tail_in[3] = 1'b1;
    dest_in[3]    = 6'h00;
    repeat (17) tick();
    checks++;
    if (flit_count0[3] !== 4'hF || pkt_count0[3] !== 4'hF) begin
      errors++;
      $display("FAIL saturate: flits=%h pkts=%h want f f", flit_count0[3], pkt_count0[3]);
    end
    checks++;
    if (flit_count[3] !== 16'd17 || pkt_count[3] !== 16'd17 || err_underflow[3] !== 1'b1) begin
      errors++;
      $display("FAIL count17: flits=%0d pkts=%0d unf=%b want 17 17 1",
               flit_count[3], pkt_count[3], err_underflow[3]);
    end
    clear_stats = 1'b1;
    tick();
    clear_stats = 1'b0;
    send_in[3]  = 1'b0;
    checks++;
    if (flit_count[3] !== 16'd0 || pkt_count[3] !== 16'd0 || flit_count0[3] !== 4'd0 ||
        err_underflow[3] !== 1'b0 || err_underflow0[3] !== 1'b0) begin
      errors++;
      $display("FAIL clear: flits=%0d pkts=%0d flits0=%0d unf=%b unf0=%b want 0",
               flit_count[3], pkt_count[3], flit_count0[3], err_underflow[3], err_underflow0[3]);
    end
    checks++;
    if (credits_avail[3] !== 3'd0) begin
      errors++;
      $display("FAIL clear_credits: got %0d want 0", credits_avail[3]);
    end
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    send_in[1]    = 1'b1;
    is_tail_in[1] = 1'b0;
    dest_in[1]    = 6'h03;
    tick();
    tick();
    checks++;
    if (pkt_active[1] !== 1'b1 || send_out[1] !== 1'b1 || credits_avail[1] !== 3'd2) begin
      errors++;
      $display("FAIL midpkt: active=%b send_out=%b credits=%0d want 1 1 2",
               pkt_active[1], send_out[1], credits_avail[1]);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (send_out[1] !== 1'b0 || credits_avail[1] !== 3'd4 || pkt_active[1] !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: send_out=%b credits=%0d active=%b want 0 4 0",
               send_out[1], credits_avail[1], pkt_active[1]);
    end
    send_in = '0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    pat_a = {4{32'hA5A5_A5A5}};
    pat_b = {4{32'h5A5A_5A5A}};
    test_reset();
    test_pipeline();
    test_underflow();
    test_same_cycle();
    test_framing();
    test_saturate_clear();
    test_reset_mid_packet();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
